logic_unit_pipe: RTL and testbench

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_pkg.sv | 16 +
 rtl/out_buf2.sv | 69 ++++++
 rtl/logic_unit_pipe.sv | 92 +++++++++
 tb/tb_logic_unit_pipe.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared opcode definitions for the bitwise logic unit.
// Provides the opcode width and the eight operation select encodings.
package logic_pkg;

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND  = 3'b000;
   localparam logic [OP_W-1:0] OP_OR   = 3'b001;
   localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
   localparam logic [OP_W-1:0] OP_NAND = 3'b011;
   localparam logic [OP_W-1:0] OP_NOR  = 3'b100;
   localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
   localparam logic [OP_W-1:0] OP_ANDN = 3'b110;
   localparam logic [OP_W-1:0] OP_PASS = 3'b111;

endpackage

// File: rtl/out_buf2.sv
// Two-entry in-order output buffer with valid/ready handshake on both sides.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push         : write push_data this edge (ignored when full)
//   push_data    : payload to store
//   pop_ready    : downstream ready; pops the head when out_valid is high
//   out_valid    : buffer holds at least one entry
//   out_data     : oldest entry
//   not_full     : registered, high iff fewer than two entries are held
module out_buf2 #(
   parameter int unsigned PW = 21
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [PW-1:0] push_data,
   input  logic          pop_ready,
   output logic          out_valid,
   output logic [PW-1:0] out_data,
   output logic          not_full
);

   logic [PW-1:0] r_mem [2];
   logic          r_head;
   logic [1:0]    r_count;
   logic          r_valid;
   logic          r_not_full;

   logic          w_push;
   logic          w_pop;
   logic          w_wr_ptr;
   logic [1:0]    w_count_nxt;

   // Handshake qualification and next occupancy
   always_comb begin
      w_push      = push & r_not_full;
      w_pop       = r_valid & pop_ready;
      // Free slot sits just past the occupied ones (mod 2)
      w_wr_ptr    = r_head ^ r_count[0];
      w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);
   end

   // Storage, pointer and occupancy state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0]   <= '0;
         r_mem[1]   <= '0;
         r_head     <= 1'b0;
         r_count    <= 2'd0;
         r_valid    <= 1'b0;
         r_not_full <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[w_wr_ptr] <= push_data;
         end
         if (w_pop) begin
            r_head <= ~r_head;
         end
         r_count    <= w_count_nxt;
         r_valid    <= (w_count_nxt != 2'd0);
         r_not_full <= ~w_count_nxt[1];
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_mem[r_head];
   assign not_full  = r_not_full;

endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with a 2-entry output buffer and handshake counter.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : request handshake (in_ready is registered)
//   in_op, in_a, in_b      : operation select and operands
//   in_tag                 : caller tag returned with the result
//   out_valid/out_ready    : result handshake
//   out_result, out_zero   : oldest result and its all-zero flag
//   out_tag                : tag of the oldest result
//   ops_done               : saturating count of output handshakes
module logic_unit_pipe
   import logic_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag,
   output logic [15:0]      ops_done
);

   localparam int unsigned PW = WIDTH + 1 + TAG_W;

   logic [WIDTH-1:0] w_result;
   logic             w_zero;
   logic [PW-1:0]    w_push_data;
   logic [PW-1:0]    w_head_data;
   logic             w_not_full;
   logic             w_out_valid;
   logic             w_push;
   logic [15:0]      r_ops_done;

   // Opcode datapath
   always_comb begin
      w_result = '0;
      case (in_op)
         OP_AND:  w_result = in_a & in_b;
         OP_OR:   w_result = in_a | in_b;
         OP_XOR:  w_result = in_a ^ in_b;
         OP_NAND: w_result = ~(in_a & in_b);
         OP_NOR:  w_result = ~(in_a | in_b);
         OP_XNOR: w_result = ~(in_a ^ in_b);
         OP_ANDN: w_result = in_a & ~in_b;
         OP_PASS: w_result = in_a;
         default: w_result = '0;
      endcase
      w_zero      = (w_result == '0);
      w_push      = in_valid & w_not_full;
      w_push_data = {w_result, w_zero, in_tag};
   end

   out_buf2 #(
      .PW (PW)
   ) u_out_buf2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data (w_push_data),
      .pop_ready (out_ready),
      .out_valid (w_out_valid),
      .out_data  (w_head_data),
      .not_full  (w_not_full)
   );

   // Saturating output handshake counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ops_done <= 16'd0;
      end else if (w_out_valid && out_ready && (r_ops_done != 16'hFFFF)) begin
         r_ops_done <= r_ops_done + 16'd1;
      end
   end

   assign in_ready   = w_not_full;
   assign out_valid  = w_out_valid;
   assign out_result = w_head_data[PW-1 -: WIDTH];
   assign out_zero   = w_head_data[TAG_W];
   assign out_tag    = w_head_data[TAG_W-1:0];
   assign ops_done   = r_ops_done;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_logic_unit_pipe;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned TAG_W = 4;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             zero;
      logic [TAG_W-1:0] tag;
   } entry_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2:0]       in_op = 3'd0;
   logic [WIDTH-1:0] in_a = '0;
   logic [WIDTH-1:0] in_b = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic [TAG_W-1:0] out_tag;
   logic [15:0]      ops_done;

   int n_vec = 0;
   int n_err = 0;

   entry_t      m_q[$];
   bit          m_rdy = 1'b0;
   logic [15:0] m_ops = 16'd0;

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_zero   (out_zero),
      .out_tag    (out_tag),
      .ops_done   (ops_done)
   );

   function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: r = a ^ b;
         3'd3: r = ~(a & b);
         3'd4: r = ~(a | b);
         3'd5: r = ~(a ^ b);
         3'd6: r = a & ~b;
         default: r = a;
      endcase
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(m_rdy));
      chk("ops_done", 64'(ops_done), 64'(m_ops));
      if (m_q.size() != 0) begin
         chk("out_result", 64'(out_result), 64'(m_q[0].res));
         chk("out_zero", 64'(out_zero), 64'(m_q[0].zero));
         chk("out_tag", 64'(out_tag), 64'(m_q[0].tag));
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_result", 64'(out_result), 64'd0);
      chk("rst_out_zero", 64'(out_zero), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_ops_done", 64'(ops_done), 64'd0);
   endtask

   // One clock: predict the handshakes from the driven inputs and model
   // state, advance the model, then compare against the DUT.
   task automatic cycle();
      bit     acc;
      bit     pop;
      entry_t e;
      acc    = rst_n && in_valid && m_rdy;
      pop    = rst_n && (m_q.size() != 0) && out_ready;
      e.res  = ref_op(in_op, in_a, in_b);
      e.zero = (e.res == '0);
      e.tag  = in_tag;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         m_q.delete();
         m_rdy = 1'b0;
         m_ops = 16'd0;
      end else begin
         if (pop) begin
            void'(m_q.pop_front());
            if (m_ops != 16'hFFFF) m_ops = m_ops + 16'd1;
         end
         if (acc) m_q.push_back(e);
         m_rdy = (m_q.size() < 2);
      end
      check_outputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      m_q.delete();
      m_rdy = 1'b0;
      m_ops = 16'd0;
      check_reset_outputs();
      cycle();
      rst_n = 1'b1;
      cycle();
   endtask

   logic [WIDTH-1:0] tbl [8];
   int               k;
   logic [15:0]      ops_before;

   initial begin
      tbl[0] = 16'hF000; tbl[1] = 16'hFFF0; tbl[2] = 16'h0FF0; tbl[3] = 16'h0FFF;
      tbl[4] = 16'h000F; tbl[5] = 16'hF00F; tbl[6] = 16'h00F0; tbl[7] = 16'hF0F0;

      // Reset state and first edge after release
      #2;
      do_reset();
      chk("in_ready_after_release", 64'(in_ready), 64'd1);

      // Full opcode sweep back-to-back with expected constants
      out_ready = 1'b1;
      in_a = 16'hF0F0;
      in_b = 16'hFF00;
      k = 0;
      for (int i = 0; i < 10; i++) begin
         in_valid = (i < 8);
         in_op    = 3'(i);
         in_tag   = 4'(i);
         cycle();
         if (out_valid) begin
            if (k < 8) begin
               chk("sweep_result", 64'(out_result), 64'(tbl[k]));
               chk("sweep_tag", 64'(out_tag), 64'(k));
            end
            k++;
         end
      end
      chk("sweep_count", 64'(k), 64'd8);

      // Zero flag
      in_valid = 1'b1; in_op = 3'd0; in_a = 16'h00FF; in_b = 16'hFF00; in_tag = 4'hA;
      cycle();
      chk("and_zero_result", 64'(out_result), 64'h0000);
      chk("and_zero_flag", 64'(out_zero), 64'd1);
      in_op = 3'd1; in_tag = 4'hB;
      cycle();
      chk("or_result", 64'(out_result), 64'hFFFF);
      chk("or_zero_flag", 64'(out_zero), 64'd0);
      in_valid = 1'b0;
      cycle();

      // Backpressure: two accepted, third waits for the first pop
      out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd7; in_a = 16'h1111;
      in_tag = 4'd1; cycle();
      in_a = 16'h2222; in_tag = 4'd2; cycle();
      in_a = 16'h3333; in_tag = 4'd3; cycle();
      chk("full_in_ready", 64'(in_ready), 64'd0);
      cycle();
      out_ready = 1'b1;
      cycle();
      chk("after_pop_in_ready", 64'(in_ready), 64'd1);
      chk("after_pop_head", 64'(out_tag), 64'd2);
      cycle();
      in_valid = 1'b0;
      chk("third_head", 64'(out_tag), 64'd3);
      chk("third_result", 64'(out_result), 64'h3333);
      cycle();

      // Simultaneous push and pop at count 1
      out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd2; in_a = 16'h5A5A; in_b = 16'h0F0F;
      in_tag = 4'd5; cycle();
      ops_before = ops_done;
      out_ready = 1'b1; in_tag = 4'd6; cycle();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("pp_valid", 64'(out_valid), 64'd1);
      chk("pp_tag", 64'(out_tag), 64'd6);
      chk("pp_ops", 64'(ops_done), 64'(ops_before + 16'd1));
      out_ready = 1'b1;
      cycle();

      // Reset mid-operation with two entries and ops_done = 5
      do_reset();
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 20 && m_ops < 16'd5; i++) begin
         in_tag = 4'(i); in_a = 16'($urandom); cycle();
      end
      out_ready = 1'b0;
      for (int i = 0; i < 5 && m_q.size() < 2; i++) cycle();
      chk("pre_rst_ops", 64'(ops_done), 64'd5);
      chk("pre_rst_count", 64'(m_q.size()), 64'd2);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      m_q.delete(); m_rdy = 1'b0; m_ops = 16'd0;
      check_reset_outputs();
      cycle();
      rst_n = 1'b1;
      cycle();
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      chk("post_rst_valid", 64'(out_valid), 64'd0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom);
         out_ready = ($urandom_range(3, 0) != 0);
         in_op     = 3'($urandom);
         in_a      = 16'($urandom);
         in_b      = ($urandom_range(3, 0) == 0) ? in_a : 16'($urandom);
         in_tag    = 4'($urandom);
         cycle();
      end

      // Counter saturation
      in_valid = 1'b0;
      do_reset();
      in_valid = 1'b1; out_ready = 1'b1; in_op = 3'd7;
      for (int i = 0; i < 70000 && m_ops != 16'hFFFF; i++) begin
         in_a = 16'(i); in_tag = 4'(i);
         cycle();
      end
      chk("sat_reached", 64'(ops_done), 64'hFFFF);
      for (int i = 0; i < 3; i++) cycle();
      chk("sat_hold", 64'(ops_done), 64'hFFFF);
      in_valid = 1'b0;
      cycle();
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
